// File: rtl/bus_datapath_pkg.sv
// Shared encodings for bus_datapath: bus source codes, load bit indices,
// ALU op codes and the memory FSM state type.
package bus_datapath_pkg;

    localparam logic [2:0] SelAr  = 3'b000;
    localparam logic [2:0] SelIr  = 3'b001;
    localparam logic [2:0] SelPc  = 3'b010;
    localparam logic [2:0] SelDr  = 3'b011;
    localparam logic [2:0] SelAc  = 3'b100;
    localparam logic [2:0] SelMdr = 3'b101;

    localparam int unsigned LdAr = 0;
    localparam int unsigned LdIr = 1;
    localparam int unsigned LdPc = 2;
    localparam int unsigned LdDr = 3;
    localparam int unsigned LdAc = 4;

    localparam logic [2:0] AluNone = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluNot  = 3'b011;
    localparam logic [2:0] AluShl  = 3'b100;
    localparam logic [2:0] AluShr  = 3'b101;
    localparam logic [2:0] AluClr  = 3'b110;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRdWait = 2'b01,
        StWrWait = 2'b10
    } mem_state_e;

endpackage

// File: rtl/bus_datapath_memport.sv
// Memory port FSM: latches address/write data on a command, holds mem_req until
// mem_ack or until the wait counter expires.
module bus_datapath_memport
    import bus_datapath_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] ar_i,
    input  logic [DATA_W-1:0] bus_i,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              rd_done_o,
    output logic              timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    mem_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              waiting;

    assign waiting   = (state_q != StIdle);
    assign rd_done_o = (state_q == StRdWait) && mem_ack;
    // Ack on the final wait cycle still counts as a completed transfer.
    assign timeout_o = waiting && !mem_ack && (cnt_q == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (mem_wr) begin
                        state_q <= StWrWait;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ar_i;
                        wdata_q <= bus_i;
                    end else if (mem_rd) begin
                        state_q <= StRdWait;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= ar_i;
                    end
                end
                StRdWait, StWrWait: begin
                    if (mem_ack || (cnt_q == CntLast)) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = req_q;

endmodule

// File: rtl/bus_datapath.sv
// Register file and shared bus with a memory port. Optional AC ALU is enabled
// by defining BUS_DATAPATH_ALU_EN.
module bus_datapath
    import bus_datapath_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        sel,
    input  logic [4:0]        load,
    input  logic [1:0]        inc,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        alu_op,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic [1:0]        err
);

    logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d, mdr_q, mdr_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] bus;
    logic              load_ok;
    logic              rd_done;
    logic              timeout;

    always_comb begin
        bus = '0;
        case (sel)
            SelAr:   bus = DATA_W'(ar_q);
            SelIr:   bus = ir_q;
            SelPc:   bus = DATA_W'(pc_q);
            SelDr:   bus = dr_q;
            SelAc:   bus = ac_q;
            SelMdr:  bus = mdr_q;
            default: bus = '0;
        endcase
    end

    assign load_ok = $onehot0(load);

    always_comb begin
        ar_d  = ar_q;
        pc_d  = pc_q;
        ir_d  = ir_q;
        dr_d  = dr_q;
        ac_d  = ac_q;
        mdr_d = rd_done ? mem_rdata : mdr_q;
        err_d = err_q | {timeout, !load_ok};

        if (inc[1]) ar_d = ar_q + ADDR_W'(1);
        if (inc[0]) pc_d = pc_q + ADDR_W'(1);
`ifdef BUS_DATAPATH_ALU_EN
        case (alu_op)
            AluAdd:  ac_d = ac_q + dr_q;
            AluAnd:  ac_d = ac_q & dr_q;
            AluNot:  ac_d = ~ac_q;
            AluShl:  ac_d = ac_q << 1;
            AluShr:  ac_d = ac_q >> 1;
            AluClr:  ac_d = '0;
            default: ac_d = ac_q;
        endcase
`endif
        // Bus loads override inc and ALU results on the same register.
        if (load_ok) begin
            if (load[LdAr]) ar_d = bus[ADDR_W-1:0];
            if (load[LdIr]) ir_d = bus;
            if (load[LdPc]) pc_d = bus[ADDR_W-1:0];
            if (load[LdDr]) dr_d = bus;
            if (load[LdAc]) ac_d = bus;
        end
    end

`ifndef BUS_DATAPATH_ALU_EN
    logic unused_alu_op;
    assign unused_alu_op = ^alu_op;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            dr_q  <= '0;
            ac_q  <= '0;
            mdr_q <= '0;
            err_q <= '0;
        end else begin
            ar_q  <= ar_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            dr_q  <= dr_d;
            ac_q  <= ac_d;
            mdr_q <= mdr_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

    bus_datapath_memport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_memport (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ar_i      (ar_q),
        .bus_i     (bus),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .rd_done_o (rd_done),
        .timeout_o (timeout)
    );

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath; internal registers are observed by issuing a
// memory write with the register on the bus and reading mem_wdata / mem_addr.
module tb_bus_datapath;

    localparam logic [2:0] TSelAr  = 3'b000;
    localparam logic [2:0] TSelIr  = 3'b001;
    localparam logic [2:0] TSelPc  = 3'b010;
    localparam logic [2:0] TSelDr  = 3'b011;
    localparam logic [2:0] TSelAc  = 3'b100;
    localparam logic [2:0] TSelMdr = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic [4:0]  load;
    logic [1:0]  inc;
    logic        mem_rd, mem_wr;
    logic [2:0]  alu_op;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic [1:0]  err;

    int n_vec = 0;
    int n_err = 0;

    bus_datapath #(
        .DATA_W  (16),
        .ADDR_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .load      (load),
        .inc       (inc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .alu_op    (alu_op),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        mem_rd = 1'b1;
        step();
        mem_rd    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = v;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic load_reg(input logic [2:0] s, input logic [4:0] ld);
        sel  = s;
        load = ld;
        step();
        load = '0;
    endtask

    task automatic peek(input logic [2:0] s, output logic [15:0] d, output logic [7:0] a);
        sel    = s;
        mem_wr = 1'b1;
        step();
        mem_wr  = 1'b0;
        d       = mem_wdata;
        a       = mem_addr;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    logic [15:0] d;
    logic [7:0]  a;

    initial begin
        rst = 1'b1; sel = '0; load = '0; inc = '0; mem_rd = 0; mem_wr = 0;
        alu_op = '0; mem_rdata = '0; mem_ack = 0;
        step(); step();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        step();

        // Read at AR=0x3C, ack on the third wait cycle.
        load_mdr(16'h003C);
        load_reg(TSelMdr, 5'b10000);
        load_reg(TSelAc, 5'b00001);
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        check("rd_req", 32'(mem_req), 32'h1);
        check("rd_we", 32'(mem_we), 32'h0);
        check("rd_addr", 32'(mem_addr), 32'h3C);
        step(); step();
        check("rd_busy_wait", 32'(busy), 32'h1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        check("rd_busy_after_ack", 32'(busy), 32'h0);
        peek(TSelMdr, d, a);
        check("rd_mdr", 32'(d), 32'hBEEF);
        check("rd_ar", 32'(a), 32'h3C);

        // PC wrap, then load-beats-inc; AR increment.
        load_mdr(16'h00FF);
        load_reg(TSelMdr, 5'b00100);
        inc = 2'b01; step(); inc = '0;
        peek(TSelPc, d, a);
        check("pc_wrap", 32'(d), 32'h0000);
        load_mdr(16'h0010);
        load_reg(TSelMdr, 5'b00100);
        load_mdr(16'h0040);
        inc = 2'b01;
        load_reg(TSelMdr, 5'b00100);
        inc = '0;
        peek(TSelPc, d, a);
        check("pc_load_wins", 32'(d), 32'h0040);
        inc = 2'b10; step(); inc = '0;
        peek(TSelAr, d, a);
        check("ar_inc", 32'(a), 32'h3D);

        // Illegal two-hot load.
        load_reg(TSelMdr, 5'b00010);
        load_mdr(16'h0077);
        check("err_before_illegal", 32'(err), 32'h0);
        load_reg(TSelMdr, 5'b00011);
        check("illegal_err", 32'(err), 32'h1);
        peek(TSelAr, d, a);
        check("illegal_ar", 32'(d), 32'h003D);
        peek(TSelIr, d, a);
        check("illegal_ir", 32'(d), 32'h0040);

        // Write with no ack runs into the timeout.
        load_mdr(16'h1234);
        load_reg(TSelMdr, 5'b10000);
        sel = TSelAc; mem_wr = 1'b1;
        step();
        mem_wr = 1'b0;
        check("wr_we", 32'(mem_we), 32'h1);
        check("wr_wdata", 32'(mem_wdata), 32'h1234);
        check("wr_addr", 32'(mem_addr), 32'h3D);
        sel = TSelAr;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) mem_rd = 1'b1;
            step();
            mem_rd = 1'b0;
        end
        check("wr_busy_last", 32'(busy), 32'h1);
        check("wr_wdata_frozen", 32'(mem_wdata), 32'h1234);
        step();
        check("to_busy", 32'(busy), 32'h0);
        check("to_err", 32'(err), 32'h3);
        step();
        check("busy_cmd_ignored", 32'(mem_req), 32'h0);

        // Simultaneous read and write: write wins.
        sel = TSelAc; mem_rd = 1'b1; mem_wr = 1'b1;
        step();
        mem_rd = 1'b0; mem_wr = 1'b0;
        check("rdwr_we", 32'(mem_we), 32'h1);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;

        // ALU add and invert on AC.
        load_mdr(16'hFFFF);
        load_reg(TSelMdr, 5'b10000);
        load_mdr(16'h0002);
        load_reg(TSelMdr, 5'b01000);
        alu_op = 3'b001; step();
        alu_op = 3'b000;
        peek(TSelAc, d, a);
`ifdef BUS_DATAPATH_ALU_EN
        check("alu_add", 32'(d), 32'h0001);
`else
        check("alu_add", 32'(d), 32'hFFFF);
`endif
        alu_op = 3'b011; step();
        alu_op = 3'b000;
        peek(TSelAc, d, a);
`ifdef BUS_DATAPATH_ALU_EN
        check("alu_not", 32'(d), 32'hFFFE);
`else
        check("alu_not", 32'(d), 32'hFFFF);
`endif

        // Reset in the middle of a read; a late ack must be ignored.
        mem_rd = 1'b1; step(); mem_rd = 1'b0;
        step();
        check("mid_rd_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_addr", 32'(mem_addr), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        step();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_ack = 1'b0;
        check("late_ack_busy", 32'(busy), 32'h0);
        check("late_ack_req", 32'(mem_req), 32'h0);
        peek(TSelMdr, d, a);
        check("late_ack_mdr", 32'(d), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
